// File: rtl/dmem_bus_if.sv
// Request/acknowledge data-bus bundle between the load/store unit (master)
// and the data memory or bus fabric (slave).
interface dmem_bus_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit: aligns stores, extends loads, stalls the pipe while
// a bus access is outstanding, and flags misaligned accesses and bus timeouts.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for mem_read/mem_write; aligned access is latched here
// BUSY  | bus_req held until bus_ack or the timeout counter expires
// DONE  | one cycle with stall low so the pipeline advances; inputs ignored
module dmem_access_unit #(
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        mem_op,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  dmem_bus_if.master        bus
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic          access, is_byte, is_half, misaligned, accept;
  logic [3:0]    be_nxt;
  logic [31:0]   wdata_nxt;
  logic          stall_c, misalign_c, bus_err_c, bus_req_c;
  logic          byte_r, half_r, unsigned_r, load_r;
  logic [1:0]    off_r;
  logic [CW-1:0] cnt;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   rdata_ext;

  // Illegal funct3 codes (011, 110, 111) fall through to word size.
  assign access     = mem_read | mem_write;
  assign is_byte    = (mem_op[1:0] == 2'b00);
  assign is_half    = (mem_op[1:0] == 2'b01);
  assign misaligned = is_half ? addr[0] : (!is_byte && (addr[1:0] != 2'b00));
  assign accept     = (state == IDLE) && access && !misaligned;

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = wdata;
    if (is_byte) begin
      be_nxt    = 4'b0001 << addr[1:0];
      wdata_nxt = {4{wdata[7:0]}};
    end else if (is_half) begin
      be_nxt    = addr[1] ? 4'b1100 : 4'b0011;
      wdata_nxt = {2{wdata[15:0]}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    stall_c    = 1'b0;
    misalign_c = 1'b0;
    bus_err_c  = 1'b0;
    bus_req_c  = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            misalign_c = 1'b1;
          end else begin
            stall_c   = 1'b1;
            state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        bus_req_c = 1'b1;
        stall_c   = 1'b1;
        // An ack in the last counted cycle wins over the timeout.
        if (bus.bus_ack) begin
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          bus_err_c = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Combinational outputs are masked by reset so they drop the moment reset asserts.
  assign stall       = stall_c & reset;
  assign misalign    = misalign_c & reset;
  assign bus_err     = bus_err_c & reset;
  assign bus.bus_req = bus_req_c & reset;

  assign lane_b = bus.bus_rdata[{off_r, 3'b000} +: 8];
  assign lane_h = off_r[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];

  always_comb begin
    rdata_ext = bus.bus_rdata;
    if (byte_r)
      rdata_ext = unsigned_r ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
    else if (half_r)
      rdata_ext = unsigned_r ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_r        <= 1'b0;
      half_r        <= 1'b0;
      unsigned_r    <= 1'b0;
      load_r        <= 1'b0;
      off_r         <= 2'b00;
      cnt           <= '0;
      rdata         <= '0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
    end else begin
      if (accept) begin
        byte_r        <= is_byte;
        half_r        <= is_half;
        unsigned_r    <= mem_op[2];
        load_r        <= !mem_write;
        off_r         <= addr[1:0];
        cnt           <= '0;
        bus.bus_we    <= mem_write;
        bus.bus_addr  <= {addr[31:2], 2'b00};
        bus.bus_be    <= be_nxt;
        bus.bus_wdata <= wdata_nxt;
      end else if ((state == BUSY) && (cnt != CNT_LAST)) begin
        cnt <= cnt + CW'(1);
      end

      if ((state == BUSY) && bus.bus_ack && load_r)
        rdata <= rdata_ext;
      else if (bus_err_c && load_r)
        rdata <= '0;
    end
  end

endmodule
